// File: rtl/pe_fx_pkg.sv
// pe_fx_pkg: fixed-point helpers shared by the dot-product PE.
//  - clog2 / idx_w : width helpers usable in parameter expressions
//  - sm_max        : largest sign-magnitude magnitude for an n-bit word
//  - sm2tc         : sign-magnitude -> two's complement (-0 maps to 0)
//  - tc2sm         : two's complement -> sign-magnitude with saturation
// All conversions work in a FXW-bit container; callers slice the width
// they need.
package pe_fx_pkg;

  localparam int FXW = 64;

  typedef struct packed {
    logic           sat;
    logic           neg;
    logic [FXW-1:0] sm;
  } sm_res_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int idx_w(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  function automatic logic [FXW-1:0] sm_max(input int n);
    return (FXW'(1) << (n - 1)) - FXW'(1);
  endfunction

  function automatic logic signed [FXW-1:0] sm2tc(input logic [FXW-1:0] sm, input int n);
    logic [FXW-1:0] mag;
    logic           sgn;
    mag = sm & sm_max(n);
    sgn = |(sm & (FXW'(1) << (n - 1)));
    if (sgn) return -$signed(mag);
    return $signed(mag);
  endfunction

  function automatic sm_res_t tc2sm(input logic signed [FXW-1:0] v, input int n);
    sm_res_t        r;
    logic [FXW-1:0] mag;
    r.neg = v[FXW-1];
    mag   = r.neg ? -v : v;
    r.sat = (mag > sm_max(n));
    if (r.sat) mag = sm_max(n);
    // A zero magnitude never carries a sign bit: the result is always +0.
    r.sm  = (r.neg && (mag != '0)) ? (mag | (FXW'(1) << (n - 1))) : mag;
    return r;
  endfunction

endpackage

// File: rtl/pe_sm_mul.sv
// pe_sm_mul: registered saturating sign-magnitude fixed-point multiply.
//  p = sign(a)^sign(b) , (|a|*|b|) >> Q truncated toward zero, saturated
//  to 2^(N-1)-1. A zero product is always +0.
// Ports:
//  clk  in  1  clock
//  en   in  1  pipeline advance (low = hold)
//  a,b  in  N  sign-magnitude operands
//  p    out N  registered sign-magnitude product
//  flag out 1  registered: product magnitude was saturated
module pe_sm_mul
  import pe_fx_pkg::*;
#(
  parameter int N = 32,
  parameter int Q = 19
) (
  input  logic         clk,
  input  logic         en,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] p,
  output logic         flag
);

  logic [2*N-3:0] full;
  logic [2*N-3:0] shifted;
  logic           sat;
  logic [N-2:0]   mag;

  always_comb begin
    full    = {{(N-1){1'b0}}, a[N-2:0]} * {{(N-1){1'b0}}, b[N-2:0]};
    shifted = full >> Q;
    sat     = |shifted[2*N-3:N-1];
    mag     = sat ? '1 : shifted[N-2:0];
  end

  // ---- S1: product register ----
  always_ff @(posedge clk) begin
    if (en) begin
      p    <= {(a[N-1] ^ b[N-1]) & (|mag), mag};
      flag <= sat;
    end
  end

endmodule

// File: rtl/pe_dot_pipe.sv
// pe_dot_pipe: pipelined sign-magnitude dot-product PE,
//  out = sum_{i<NCH} in[i]*w[i], one vector per cycle, latency T+3
//  (T = clog2(NCH)). A stalled output freezes the whole pipe.
// Ports:
//  clk, rst            clock, synchronous active-high reset
//  in_valid/in_ready   input handshake, in_data channel i at [i*N +: N]
//  w_we/w_idx/w_data   weight bank write (idx >= NCH ignored)
//  out_valid/out_ready output handshake, out_data sign-magnitude result
//  ovf / ovf_clr       sticky saturation flag and its clear
// Build option: define PE_RELU_EN to clamp negative results to 0.
module pe_dot_pipe
  import pe_fx_pkg::*;
#(
  parameter  int N   = 32,
  parameter  int Q   = 19,
  parameter  int NCH = 4,
  localparam int WIW = idx_w(NCH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NCH*N-1:0] in_data,
  input  logic             w_we,
  input  logic [WIW-1:0]   w_idx,
  input  logic [N-1:0]     w_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_data,
  output logic             ovf,
  input  logic             ovf_clr
);

  localparam int T  = clog2(NCH);
  localparam int NP = 1 << T;
  localparam int SW = N + T;

  logic             en;
  logic [N-1:0]     w_bank [NCH];

  logic             vld_p0;
  logic [NCH*N-1:0] in_p0;
  logic [NCH*N-1:0] wt_p0;

  logic             vld_p1;
  logic [N-1:0]     prod_p1 [NCH];
  logic [NCH-1:0]   pflag_p1;

  logic signed [FXW-1:0] tc_wide [NCH];
  // tree[l] is registered at stage p(2+l); tree[0] holds the converted products.
  logic signed [SW-1:0]  tree [T+1][NP];
  logic [T:0]            lvl_vld;
  logic [T:0]            lvl_flag;

  sm_res_t          so_res;
  logic [N-1:0]     so_data;
  logic             so_flag;
  logic             unused_bits;

  assign en       = ~(out_valid & ~out_ready);
  assign in_ready = en;

  // Weight bank: a write lands at the edge, so a vector captured at the same
  // edge still sees the old weight.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) w_bank[i] <= '0;
    end else if (w_we) begin
      for (int i = 0; i < NCH; i++)
        if (w_idx == WIW'(i)) w_bank[i] <= w_data;
    end
  end

  // ---- S0: capture input vector and current weights ----
  always_ff @(posedge clk) begin
    if (rst) vld_p0 <= 1'b0;
    else if (en) vld_p0 <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (en) begin
      in_p0 <= in_data;
      for (int i = 0; i < NCH; i++) wt_p0[i*N +: N] <= w_bank[i];
    end
  end

  // ---- S1: per-channel multiply ----
  for (genvar i = 0; i < NCH; i++) begin : g_mul
    pe_sm_mul #(.N(N), .Q(Q)) u_mul (
      .clk  (clk),
      .en   (en),
      .a    (in_p0[i*N +: N]),
      .b    (wt_p0[i*N +: N]),
      .p    (prod_p1[i]),
      .flag (pflag_p1[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) vld_p1 <= 1'b0;
    else if (en) vld_p1 <= vld_p0;
  end

  always_comb begin
    for (int i = 0; i < NCH; i++) tc_wide[i] = sm2tc(FXW'(prod_p1[i]), N);
  end

  // ---- P2 and tree levels: two's complement reduction, N+T bits is exact ----
  always_ff @(posedge clk) begin
    if (en) begin
      for (int j = 0; j < NCH; j++) tree[0][j] <= tc_wide[j][SW-1:0];
      for (int j = NCH; j < NP; j++) tree[0][j] <= '0;
      lvl_flag[0] <= |pflag_p1;
      for (int l = 0; l < T; l++) begin
        for (int j = 0; j < (NP >> (l + 1)); j++)
          tree[l+1][j] <= tree[l][2*j] + tree[l][2*j+1];
        lvl_flag[l+1] <= lvl_flag[l];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lvl_vld <= '0;
    end else if (en) begin
      lvl_vld[0] <= vld_p1;
      for (int l = 0; l < T; l++) lvl_vld[l+1] <= lvl_vld[l];
    end
  end

  always_comb begin
    so_res  = tc2sm($signed({{(FXW-SW){tree[T][0][SW-1]}}, tree[T][0]}), N);
    so_data = so_res.sm[N-1:0];
`ifdef PE_RELU_EN
    if (so_res.neg) so_data = '0;
`else
    so_data = so_res.sm[N-1:0];
`endif
    so_flag = so_res.sat | lvl_flag[T];
    // Container bits above the working widths are never needed.
    unused_bits = ^so_res.sm[FXW-1:N];
    for (int i = 0; i < NCH; i++) unused_bits = unused_bits ^ (^tc_wide[i][FXW-1:SW]);
  end

  // ---- SO: sign-magnitude output register and sticky overflow ----
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      ovf       <= 1'b0;
    end else begin
      if (en) begin
        out_valid <= lvl_vld[T];
        out_data  <= so_data;
      end
      if (ovf_clr) ovf <= 1'b0;
      if (en && lvl_vld[T] && so_flag) ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pe_dot_pipe.sv
// tb_pe_dot_pipe: directed scoreboard bench for pe_dot_pipe (N=32, Q=19, NCH=4).
// Expected results are pushed when a vector is accepted and popped when the
// PE hands a result over. Define PE_RELU_EN to match a ReLU build.
module tb_pe_dot_pipe;

  localparam logic [31:0] ONE   = 32'h00080000;
  localparam logic [31:0] TWO   = 32'h00100000;
  localparam logic [31:0] PI    = 32'h001921FB;
  localparam logic [31:0] NPI   = 32'h801921FB;
  localparam logic [31:0] K2000 = 32'h3E800000;
  localparam logic [31:0] MAXV  = 32'h7FFFFFFF;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, w_we, out_valid, out_ready, ovf, ovf_clr;
  logic [127:0] in_data;
  logic [1:0]   w_idx;
  logic [31:0]  w_data, out_data;

  int           checks = 0;
  int           failures = 0;
  logic [31:0]  sbq[$];
  logic [31:0]  wm[4];
  logic [127:0] vs[8];

  always #5 clk = ~clk;

  pe_dot_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .w_we(w_we), .w_idx(w_idx), .w_data(w_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .ovf(ovf), .ovf_clr(ovf_clr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] vec(input logic [31:0] a0, a1, a2, a3);
    return {a3, a2, a1, a0};
  endfunction

  // Reference dot product against the bench's own copy of the weights.
  function automatic logic [31:0] model(input logic [127:0] v);
    longint          sum;
    longint          sp;
    longint unsigned ma, mb, p, mag;
    logic [31:0]     a, b;
    logic            neg;
    sum = 0;
    for (int i = 0; i < 4; i++) begin
      a  = v[i*32 +: 32];
      b  = wm[i];
      ma = {33'b0, a[30:0]};
      mb = {33'b0, b[30:0]};
      p  = (ma * mb) >> 19;
      if (p > 64'h7FFFFFFF) p = 64'h7FFFFFFF;
      sp = (a[31] ^ b[31]) ? -longint'(p) : longint'(p);
      sum += sp;
    end
    neg = (sum < 0);
    mag = neg ? longint'(-sum) : longint'(sum);
    if (mag > 64'h7FFFFFFF) mag = 64'h7FFFFFFF;
`ifdef PE_RELU_EN
    if (neg) return 32'h0;
`endif
    return {neg, mag[30:0]};
  endfunction

  task automatic wr(input logic [1:0] idx, input logic [31:0] d);
    w_we = 1'b1; w_idx = idx; w_data = d;
    @(posedge clk); #1;
    w_we = 1'b0;
    wm[idx] = d;
  endtask

  task automatic send(input logic [127:0] v, input logic [31:0] e);
    int n;
    n = 0;
    in_data = v; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("send_in_ready", {31'b0, in_ready}, 32'd1);
    sbq.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_remaining", sbq.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  // Scoreboard monitor: a result is taken at the next rising edge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sbq.size() == 0) chk("unexpected_out", {31'b0, out_valid}, 32'd0);
      else chk("out_data", out_data, sbq.pop_front());
    end
  end

  initial begin
    int j;
    logic seen;
    logic [31:0] x;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; w_we = 1'b0; w_idx = '0; w_data = '0;
    out_ready = 1'b1; ovf_clr = 1'b0;
    for (int i = 0; i < 4; i++) wm[i] = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_ovf", {31'b0, ovf}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // 2pi with latency measurement
    wr(0, ONE); wr(1, ONE);
    send(vec(PI, PI, 0, 0), 32'h003243F6);
    j = 0;
    @(negedge clk);
    while (!out_valid && j < 20) begin
      @(negedge clk);
      j++;
    end
    chk("latency", j, 32'd5);
    drain();
    chk("ovf_after_2pi", {31'b0, ovf}, 32'd0);

    // truncation of tiny products
    wr(0, 32'h1); wr(1, 32'h1);
    send(vec(PI, PI, 0, 0), 32'h00000006);
    drain();

    // weight write in the accept cycle uses the old weight
    wr(0, ONE); wr(1, 0);
    in_data = vec(PI, 0, 0, 0); in_valid = 1'b1;
    w_we = 1'b1; w_idx = 2'd0; w_data = TWO;
    @(negedge clk);
    chk("wsame_in_ready", {31'b0, in_ready}, 32'd1);
    sbq.push_back(PI);
    @(posedge clk); #1;
    w_we = 1'b0; in_valid = 1'b0; wm[0] = TWO;
    send(vec(PI, 0, 0, 0), 32'h003243F6);
    drain();

    // saturation and sticky overflow
    for (int i = 0; i < 4; i++) wr(2'(i), K2000);
    send(vec(K2000, K2000, K2000, K2000), MAXV);
    drain();
    chk("ovf_set", {31'b0, ovf}, 32'd1);
    ovf_clr = 1'b1;
    @(posedge clk); #1 ovf_clr = 1'b0;
    @(negedge clk);
    chk("ovf_cleared", {31'b0, ovf}, 32'd0);
    @(posedge clk); #1;

    // set and clear in the same cycle: set wins
    ovf_clr = 1'b1;
    send(vec(K2000, K2000, K2000, K2000), MAXV);
    j = 0;
    @(negedge clk);
    while (!out_valid && j < 20) begin
      @(negedge clk);
      j++;
    end
    chk("ovf_set_wins", {31'b0, ovf}, 32'd1);
    @(posedge clk); #1 ovf_clr = 1'b0;
    @(negedge clk);
    chk("ovf_clr_after", {31'b0, ovf}, 32'd0);
    drain();

    // back-to-back stream with an output stall
    for (int i = 0; i < 3; i++) begin
      x = $urandom_range(0, 32'h003FFFFF);
      x[31] = 1'($urandom_range(0, 1));
      wr(2'(i), x);
    end
    wr(3, 32'h80000000);
    for (int k = 0; k < 8; k++) begin
      for (int c = 0; c < 4; c++) begin
        x = $urandom_range(0, 32'h003FFFFF);
        x[31] = 1'($urandom_range(0, 1));
        vs[k][c*32 +: 32] = x;
      end
    end
    vs[2][31:0] = 32'h80000000;
    fork
      begin
        for (int k = 0; k < 8; k++) send(vs[k], model(vs[k]));
      end
      begin
        repeat (6) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (4) begin
          @(negedge clk);
          chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
          chk("stall_out_valid", {31'b0, out_valid}, 32'd1);
          @(posedge clk);
        end
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // negative result, then reset with a vector in flight
    wr(0, ONE); wr(1, 0); wr(2, 0); wr(3, 0);
`ifdef PE_RELU_EN
    send(vec(NPI, 0, 0, 0), 32'h00000000);
`else
    send(vec(NPI, 0, 0, 0), NPI);
`endif
    drain();
    send(vec(NPI, 0, 0, 0), model(vec(NPI, 0, 0, 0)));
    @(posedge clk); #1 rst = 1'b1;
    sbq.delete();
    for (int i = 0; i < 4; i++) wm[i] = '0;
    @(posedge clk); #1 rst = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      seen = seen | out_valid;
    end
    chk("no_out_after_rst", {31'b0, seen}, 32'd0);
    chk("ovf_after_rst", {31'b0, ovf}, 32'd0);
    @(posedge clk); #1;
    send(vec(PI, PI, PI, PI), 32'h00000000);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
